// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: instruction memory port, redirect input and output handshake.
// master = fetch unit side, slave = surrounding pipeline/memory side.
interface instruction_fetch_unit_if;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;

  modport master (
    input  fetch_en, imem_instr, redirect_valid, redirect_target, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fault
  );

  modport slave (
    output fetch_en, imem_instr, redirect_valid, redirect_target, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch: PC register, 2-entry {instr, pc} buffer,
// redirect flush and sticky fault on misaligned/out-of-range PC.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] head_instr, head_pc, head_pc4;
  logic [XLEN-1:0] tail_instr, tail_pc;
  logic [1:0]      count;
  logic [1:0]      count_nxt;
  logic            valid_q;
  logic            fault_q;
  logic            legal, pop, room, push;

  // Head entry lives directly in the output registers; tail holds the second entry.
  always_comb begin
    legal     = 1'b0;
    pop       = 1'b0;
    room      = 1'b0;
    push      = 1'b0;
    count_nxt = count;
    legal = (pc[1:0] == 2'b00) && ({2'b00, pc[XLEN-1:2]} < 32'(MEM_WORDS));
    pop   = valid_q & bus.out_ready;
    room  = (count < 2'd2) || pop;
    push  = !bus.redirect_valid && (state == RUN) && bus.fetch_en && legal && room;
    if (bus.redirect_valid) begin
      count_nxt = 2'd0;
    end else begin
      count_nxt = count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      count      <= 2'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      head_instr <= '0;
      head_pc    <= '0;
      head_pc4   <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else begin
      count   <= count_nxt;
      valid_q <= (count_nxt != 2'd0);

      if (bus.redirect_valid) begin
        pc      <= bus.redirect_target;
        fault_q <= 1'b0;
        state   <= bus.fetch_en ? RUN : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.fetch_en) state <= RUN;
          end
          RUN: begin
            if (!bus.fetch_en) begin
              state <= IDLE;
            end else if (!legal) begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end else if (push) begin
              pc <= pc + 32'd4;
            end
          end
          FAULT: begin
          end
          default: state <= IDLE;
        endcase

        // Buffer movement; a flush leaves the last head visible but invalid.
        if (pop && (count == 2'd2)) begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          head_pc4   <= tail_pc + 32'd4;
          if (push) begin
            tail_instr <= bus.imem_instr;
            tail_pc    <= pc;
          end
        end else if (push) begin
          if ((count == 2'd0) || pop) begin
            head_instr <= bus.imem_instr;
            head_pc    <= pc;
            head_pc4   <= pc + 32'd4;
          end else begin
            tail_instr <= bus.imem_instr;
            tail_pc    <= pc;
          end
        end
      end
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.out_valid    = valid_q;
  assign bus.out_instr    = head_instr;
  assign bus.out_pc       = head_pc;
  assign bus.out_pc_plus4 = head_pc4;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based fetch model,
// with directed scenarios pinning latency, backpressure, redirect, fault and reset.
module tb_instruction_fetch_unit;

  localparam int unsigned MEM_WORDS = 64;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];
  assign bus.imem_instr = (bus.imem_addr[31:2] < 30'(MEM_WORDS)) ? mem[bus.imem_addr[7:2]]
                                                                   : 32'hBAD0_0000;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a fetcher must have buffered and shown, step by step.
  entry_t      q[$];
  logic [31:0] m_pc, m_oi, m_op, m_op4;
  bit          m_act, m_flt, m_pop, m_room;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pc  = RESET_PC;
      m_act = 1'b0;
      m_flt = 1'b0;
      m_oi  = '0;
      m_op  = '0;
      m_op4 = '0;
    end else begin
      m_pop  = (q.size() > 0) && bus.out_ready;
      m_room = (q.size() < 2) || m_pop;
      if (m_pop) void'(q.pop_front());
      if (bus.redirect_valid) begin
        q.delete();
        m_pc  = bus.redirect_target;
        m_flt = 1'b0;
        m_act = bus.fetch_en;
      end else if (m_flt) begin
      end else if (!m_act) begin
        m_act = bus.fetch_en;
      end else if (!bus.fetch_en) begin
        m_act = 1'b0;
      end else if ((m_pc % 4 != 0) || (m_pc / 4 >= MEM_WORDS)) begin
        m_flt = 1'b1;
      end else if (m_room) begin
        q.push_back('{mem[m_pc / 4], m_pc});
        m_pc = m_pc + 32'd4;
      end
      if (q.size() > 0) begin
        m_oi  = q[0].instr;
        m_op  = q[0].pc;
        m_op4 = q[0].pc + 32'd4;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("out_instr", bus.out_instr, m_oi);
      chk("out_pc", bus.out_pc, m_op);
      chk("out_pc_plus4", bus.out_pc_plus4, m_op4);
      chk("fault", 32'(bus.fault), 32'(m_flt));
    end
  end

  task automatic redirect_to(input logic [31:0] tgt);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = tgt;
    @(negedge clk);
    bus.redirect_valid  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_instr"}, bus.out_instr, 32'd0);
    chk({tag, "_pc"}, bus.out_pc, 32'd0);
    chk({tag, "_pc4"}, bus.out_pc_plus4, 32'd0);
    chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, RESET_PC);
  endtask

  int r;

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0000;
    bus.fetch_en        = 1'b1;
    bus.out_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;

    // Reset state and first fetch latency
    repeat (2) @(negedge clk);
    chk_zero("rst");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_addr", bus.imem_addr, 32'h0);
    chk("first_valid0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_instr", bus.out_instr, 32'h2008_0000);
    chk("first_pc", bus.out_pc, 32'h0);
    chk("first_pc4", bus.out_pc_plus4, 32'h4);
    @(negedge clk);
    chk("second_pc", bus.out_pc, 32'h4);
    chk("second_instr", bus.out_instr, mem[1]);

    // Backpressure: buffer saturates at two entries, PC freezes
    bus.out_ready = 1'b0;
    redirect_to(32'h0);
    repeat (3) @(negedge clk);
    chk("bp_addr", bus.imem_addr, 32'h8);
    chk("bp_pc", bus.out_pc, 32'h0);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("bp_addr_hold", bus.imem_addr, 32'h8);
    chk("bp_pc_hold", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain1", bus.out_pc, 32'h4);
    @(negedge clk);
    chk("bp_drain2", bus.out_pc, 32'h8);

    // Redirect with head handshake in the same cycle
    bus.out_ready = 1'b0;
    redirect_to(32'h2C);
    repeat (2) @(negedge clk);
    chk("rd_head", bus.out_pc, 32'h2C);
    bus.out_ready = 1'b1;
    redirect_to(32'h24);
    chk("rd_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_flush_hold", bus.out_pc, 32'h2C);
    @(negedge clk);
    chk("rd_new_valid", 32'(bus.out_valid), 32'd1);
    chk("rd_new_pc", bus.out_pc, 32'h24);

    // Running off the end of memory
    redirect_to(32'hF8);
    @(negedge clk);
    chk("end_pc0", bus.out_pc, 32'hF8);
    @(negedge clk);
    chk("end_pc1", bus.out_pc, 32'hFC);
    @(negedge clk);
    chk("end_fault", 32'(bus.fault), 32'd1);
    chk("end_valid", 32'(bus.out_valid), 32'd0);
    chk("end_addr", bus.imem_addr, 32'h100);
    repeat (2) @(negedge clk);
    chk("end_fault_sticky", 32'(bus.fault), 32'd1);
    redirect_to(32'h0);
    chk("end_fault_clr", 32'(bus.fault), 32'd0);
    @(negedge clk);
    chk("end_resume", bus.out_pc, 32'h0);

    // Misaligned target, then asynchronous reset mid-stream
    redirect_to(32'h22);
    chk("mis_fault0", 32'(bus.fault), 32'd0);
    @(negedge clk);
    chk("mis_fault1", 32'(bus.fault), 32'd1);
    chk("mis_valid", 32'(bus.out_valid), 32'd0);
    redirect_to(32'h10);
    repeat (2) @(negedge clk);
    chk("pre_rst_pc", bus.out_pc, 32'h14);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_restart_addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    chk("rst_restart_pc", bus.out_pc, RESET_PC);
    chk("rst_restart_instr", bus.out_instr, 32'h2008_0000);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.fetch_en       = ($urandom_range(0, 9) != 0);
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 7)       bus.redirect_target = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (r == 7) bus.redirect_target = 32'hF0 + 32'(4 * $urandom_range(0, 3));
      else if (r == 8) bus.redirect_target = $urandom;
      else             bus.redirect_target = 32'h100;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
